rsa_job_arbiter: RTL and testbench
==================================

Name: rsa_job_arbiter

Overview:
- Shares one RSA exponentiation core between two independent requesters using round-robin arbitration.
- Latches the winner's operands and holds them stable for the whole run. Sequences the core enable, captures the result on end-of-conversion, and returns it with the requester ID over a valid/ready response channel.
- Sits between the host-side request ports and the RSA core instance.

Parameters:
- WIDTH, 8, operand and result width in bits (P, E, M, Const, C).
- TIMEOUT_CYCLES, 4095, maximum RUN cycles before abort; used only when RSA_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_p, req0_e, req0_m, req0_const  in  WIDTH each  requester 0 operands.
- req1_valid  in  1  requester 1 has a job.
- req1_ready  out  1  requester 1 job accepted this cycle.
- req1_p, req1_e, req1_m, req1_const  in  WIDTH each  requester 1 operands.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_c  out  WIDTH  result C.
- rsp_err  out  1  job aborted by timeout; tied 0 without the macro.
- busy  out  1  high in any state other than IDLE.
- core_en  out  1  RSA core enable.
- core_p, core_e, core_m, core_const  out  WIDTH each  latched operands to the core.
- core_c  in  WIDTH  core result.
- core_eoc  in  1  core end-of-conversion.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE, last_grant=1 so requester 0 wins the first tie. All outputs 0, operand/result registers 0.
- States: IDLE, RUN, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester opposite last_grant.
  - In the grant cycle: reqN_ready=1 combinationally for that requester only. Latch its operands into core_* registers, store the ID, update last_grant, go to RUN.
  - With no valid, stay in IDLE.
- RUN:
  - core_en=1 for every cycle in RUN; core_* operands constant.
  - On core_eoc=1: capture core_c into the result register, go to RESP.
- RESP:
  - core_en=0; rsp_valid=1 with rsp_id, rsp_c and rsp_err stable.
  - On rsp_valid & rsp_ready: go to IDLE.
  - RESP lasts at least one cycle, which guarantees core_en is low for at least one cycle between jobs and returns the core FSM to idle.
- Latency:
  - Accept at cycle t.
  - core_en high from t+1.
  - eoc sampled at cycle u gives rsp_valid at u+1.
  - Back-to-back minimum spacing is 3 cycles per job plus core runtime.
- core_eoc outside RUN is ignored.
- reqN_ready is never high outside IDLE, and never high for both requesters in the same cycle.
- A requester may drop valid before it is granted; no job is recorded.
- rsp_ready while rsp_valid is low has no effect.
- Reset in any state aborts the job silently: no response, core_en drops immediately.

Optional Feature:
- Macro: RSA_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without core_eoc, go to RESP with rsp_err=1 and rsp_c=0. core_en drops at the same time.
  - If eoc and timeout occur in the same cycle, eoc wins and rsp_err=0.
- When undefined: no counter is built, rsp_err is constant 0, and RUN waits indefinitely.

Test Plan:
- Single job: req0 P=4,E=13,M=497,Const per core convention (WIDTH=10), req1 idle -> req0_ready one cycle, core_en high until eoc, rsp_valid with rsp_id=0 and rsp_c equal to the golden 4^13 mod 497=445.
- Simultaneous requests from reset with distinct operands -> req0 served first, then req1; each rsp_c matches its own golden value; rsp_id sequence 0,1.
- Both requesters continuously valid for 4 jobs -> grants alternate 0,1,0,1; never two readies in one cycle.
- Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_c stable; no new grant and core_en=0 throughout; accept -> IDLE next cycle.
- Assert rstb low mid-RUN -> core_en, busy and rsp_valid low immediately; after release, the next req0 job completes correctly with last_grant reset.
- With RSA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, core_eoc held 0 -> rsp_valid at RUN cycle 20 with rsp_err=1 and rsp_c=0; the next job then completes normally with rsp_err=0.

Source files
------------

// File: rtl/rsa_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rsa_job_arbiter
// Purpose  : Round-robin sharing of one RSA exponentiation core between two
//            requesters. Latches the winner's operands, runs the core until
//            end-of-conversion, and returns the result with the owner ID over
//            a valid/ready response channel.
// Options  : RSA_ARB_TIMEOUT_EN - abort a RUN after TIMEOUT_CYCLES cycles
//            without core_eoc and flag the response with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_job_arbiter #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic             clk,
  input  logic             rstb,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_p,
  input  logic [WIDTH-1:0] req0_e,
  input  logic [WIDTH-1:0] req0_m,
  input  logic [WIDTH-1:0] req0_const,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_p,
  input  logic [WIDTH-1:0] req1_e,
  input  logic [WIDTH-1:0] req1_m,
  input  logic [WIDTH-1:0] req1_const,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic             busy,
  // RSA core side
  output logic             core_en,
  output logic [WIDTH-1:0] core_p,
  output logic [WIDTH-1:0] core_e,
  output logic [WIDTH-1:0] core_m,
  output logic [WIDTH-1:0] core_const,
  input  logic [WIDTH-1:0] core_c,
  input  logic             core_eoc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_core_en;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_const;
  logic [WIDTH-1:0] r_c;
  logic             w_grant0;
  logic             w_grant1;

  // Round-robin pick while idle: a lone requester wins, a tie goes to the
  // requester that did not win last time. Held low during reset.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rstb && (r_state == ST_IDLE)) begin
      if (req0_valid && (!req1_valid || r_last_grant)) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_run_cnt;
  logic             r_rsp_err;
  logic             w_timeout;

  // Last permitted RUN cycle: counter has already counted TIMEOUT_CYCLES-1
  assign w_timeout = (r_state == ST_RUN) &&
                     (r_run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // RUN-cycle counter, held at zero outside RUN so every job starts fresh
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_run_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_run_cnt <= '0;
    end else begin
      r_run_cnt <= r_run_cnt + CNT_W'(1);
    end
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign rsp_err          = 1'b0;
`endif

  // Job sequencer: grant/latch in IDLE, run the core, hold the response
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_core_en    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_p          <= '0;
      r_e          <= '0;
      r_m          <= '0;
      r_const      <= '0;
      r_c          <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_p          <= w_grant1 ? req1_p     : req0_p;
            r_e          <= w_grant1 ? req1_e     : req0_e;
            r_m          <= w_grant1 ? req1_m     : req0_m;
            r_const      <= w_grant1 ? req1_const : req0_const;
            r_rsp_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_core_en    <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // eoc takes priority over a coincident timeout
          if (core_eoc) begin
            r_c         <= core_c;
            r_core_en   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef RSA_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_c         <= '0;
            r_core_en   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
`ifdef RSA_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
        end
        default: begin
          r_core_en   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_c      = r_c;
  assign busy       = (r_state != ST_IDLE);
  assign core_en    = r_core_en;
  assign core_p     = r_p;
  assign core_e     = r_e;
  assign core_m     = r_m;
  assign core_const = r_const;

endmodule
`default_nettype wire

// File: tb/tb_rsa_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_job_arbiter
// Purpose  : Self-checking bench for rsa_job_arbiter with a behavioural RSA
//            core and a transaction-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_job_arbiter;

  localparam int W  = 10;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_p = '0, req0_e = '0, req0_m = '0, req0_const = '0;
  logic [W-1:0] req1_p = '0, req1_e = '0, req1_m = '0, req1_const = '0;
  logic         rsp_valid, rsp_id, rsp_err, busy, core_en;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_c, core_p, core_e, core_m, core_const;
  logic [W-1:0] core_c = '0;
  logic         core_eoc = 1'b0;

  int tests = 0;
  int fails = 0;

  // core model control: 0 normal, 1 never finishes, 2 eoc stuck high
  int core_mode = 0;
  int core_lat  = 1;
  int run_cnt   = 0;

  rsa_job_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstb(rstb),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_p(req0_p), .req0_e(req0_e), .req0_m(req0_m), .req0_const(req0_const),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_p(req1_p), .req1_e(req1_e), .req1_m(req1_m), .req1_const(req1_const),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_err(rsp_err), .busy(busy),
    .core_en(core_en), .core_p(core_p), .core_e(core_e), .core_m(core_m),
    .core_const(core_const), .core_c(core_c), .core_eoc(core_eoc)
  );

  always #5 clk = ~clk;

  // Golden modular exponentiation p^e mod m
  function automatic logic [W-1:0] golden(input logic [W-1:0] p, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    longint r, b, mm;
    mm = longint'(m);
    r  = 1 % mm;
    b  = longint'(p) % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return W'(r);
  endfunction

  // Behavioural core: finishes core_lat cycles after enable, garbage otherwise
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (core_mode == 2) begin
        core_eoc = 1'b1;
        core_c   = W'($urandom);
      end else if (core_en && core_mode == 0) begin
        if (run_cnt == 0) core_lat = $urandom_range(1, 6);
        run_cnt++;
        if (run_cnt >= core_lat) begin
          core_eoc = 1'b1;
          core_c   = golden(core_p, core_e, core_m);
        end else begin
          core_eoc = 1'b0;
          core_c   = W'($urandom);
        end
      end else begin
        run_cnt  = 0;
        core_eoc = 1'b0;
        core_c   = W'($urandom);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rand_ops(input int which);
    if (which == 0) begin
      req0_p = W'($urandom); req0_e = W'($urandom);
      req0_m = W'($urandom_range(2, 1023)); req0_const = W'($urandom);
    end else begin
      req1_p = W'($urandom); req1_e = W'($urandom);
      req1_m = W'($urandom_range(2, 1023)); req1_const = W'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0; core_mode = 0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  // Waits at negedges until rsp_valid, counting cycles with core_en high
  task automatic wait_rsp(input int max_cyc, output bit ok, output int en_cyc);
    ok = 1'b0; en_cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
      if (core_en) en_cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstb = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    tests++;
    if ({busy, core_en, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, core_en, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready});
    end
    tests++;
    if ({core_p, core_e, core_m, core_const, rsp_c} !== '0) begin
      fails++;
      $display("FAIL reset_data: got p=%0d e=%0d m=%0d k=%0d c=%0d required all 0",
               core_p, core_e, core_m, core_const, rsp_c);
    end
    @(posedge clk); #1 rstb = 1'b1;
  endtask

  task automatic test_single_job();
    bit ok; int en;
    logic [W-1:0] k;
    k = W'($urandom);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_p = 10'd4; req0_e = 10'd13; req0_m = 10'd497; req0_const = k;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL single_ready: got %b required 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_p = 10'd99; req0_e = 10'd1; req0_m = 10'd7;
    @(negedge clk);
    tests++;
    if ({core_en, busy} !== 2'b11 || {core_p, core_e, core_m, core_const} !== {10'd4, 10'd13, 10'd497, k}) begin
      fails++;
      $display("FAIL single_latch: en=%b busy=%b p=%0d e=%0d m=%0d k=%0d required 1 1 4 13 497 %0d",
               core_en, busy, core_p, core_e, core_m, core_const, k);
    end
    wait_rsp(50, ok, en);
    en = en + 1;  // the RUN cycle already consumed by the latch check above
    tests++;
    if (!ok || en != core_lat) begin
      fails++; $display("FAIL single_latency: ok=%0d en_cycles=%0d required 1 %0d", ok, en, core_lat);
    end
    tests++;
    if ({rsp_id, rsp_err, core_en} !== 3'b000 || rsp_c !== 10'd445) begin
      fails++;
      $display("FAIL single_rsp: id=%b err=%b en=%b c=%0d required 0 0 0 445", rsp_id, rsp_err, core_en, rsp_c);
    end
    @(negedge clk);
    tests++;
    if ({busy, rsp_valid} !== 2'b00) begin
      fails++; $display("FAIL single_done: busy=%b valid=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_c[$];
    int got = 0, grants = 0;
    bit both = 1'b0, r0, r1;
    do_reset();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rand_ops(0); rand_ops(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 400 && got < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready) begin exp_c.push_back(golden(req0_p, req0_e, req0_m)); grants++; end
      if (req1_ready) begin exp_c.push_back(golden(req1_p, req1_e, req1_m)); grants++; end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (got >= exp_c.size() || rsp_id !== 1'(got % 2) || rsp_c !== exp_c[got] || rsp_err !== 1'b0) begin
          fails++;
          $display("FAIL b2b_rsp%0d: id=%b c=%0d err=%b required id=%0d c=%0d err=0", got, rsp_id, rsp_c,
                   rsp_err, got % 2, (got < exp_c.size()) ? exp_c[got] : 0);
        end
        got++;
      end
      r0 = req0_ready; r1 = req1_ready;
      @(posedge clk); #1;
      if (r0) rand_ops(0);
      if (r1) rand_ops(1);
      if (grants >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    tests++;
    if (got != 4 || both) begin
      fails++; $display("FAIL b2b_count: responses=%0d dual_ready=%0d required 4 0", got, both);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok; int en;
    logic [W-1:0] c0, c1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    rand_ops(0); req0_valid = 1'b1;
    c0 = golden(req0_p, req0_e, req0_m);
    @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(50, ok, en);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_wait: no response seen required rsp_valid=1"); end
    @(posedge clk); #1;
    rand_ops(1); req1_valid = 1'b1; core_mode = 2;
    c1 = golden(req1_p, req1_e, req1_m);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_id, core_en, req0_ready, req1_ready} !== 5'b10000 || rsp_c !== c0) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b id=%b en=%b rdy=%b%b c=%0d required 1 0 0 00 c=%0d", i,
                 rsp_valid, rsp_id, core_en, req0_ready, req1_ready, rsp_c, c0);
      end
      @(posedge clk); #1;
    end
    core_mode = 0; rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, rsp_valid, req1_ready} !== 3'b001) begin
      fails++; $display("FAIL bp_release: busy=%b valid=%b rdy1=%b required 0 0 1", busy, rsp_valid, req1_ready);
    end
    @(posedge clk); #1 req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_rsp(50, ok, en);
    tests++;
    if (!ok || rsp_id !== 1'b1 || rsp_c !== c1) begin
      fails++; $display("FAIL bp_next: ok=%0d id=%b c=%0d required 1 1 %0d", ok, rsp_id, rsp_c, c1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit ok; int en;
    logic [W-1:0] c0;
    core_mode = 1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rand_ops(0); req0_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (core_en !== 1'b1) begin fails++; $display("FAIL mid_run_en: en=%b required 1", core_en); end
    #2 rstb = 1'b0;
    #1;
    tests++;
    if ({core_en, busy, rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL mid_reset: en=%b busy=%b valid=%b required 0 0 0", core_en, busy, rsp_valid);
    end
    @(posedge clk); #1;
    rstb = 1'b1; core_mode = 0;
    rand_ops(0); rand_ops(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    c0 = golden(req0_p, req0_e, req0_m);
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL post_reset_tie: rdy=%b%b required 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(50, ok, en);
    tests++;
    if (!ok || rsp_id !== 1'b0 || rsp_c !== c0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL post_reset_job: ok=%0d id=%b c=%0d err=%b required 1 0 %0d 0", ok, rsp_id, rsp_c, rsp_err, c0);
    end
    @(negedge clk);
  endtask

`ifdef RSA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int en;
    logic [W-1:0] c1;
    core_mode = 1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rand_ops(0); req0_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(100, ok, en);
    tests++;
    if (!ok || en != TO || rsp_err !== 1'b1 || rsp_c !== '0 || core_en !== 1'b0) begin
      fails++;
      $display("FAIL timeout_rsp: ok=%0d run=%0d err=%b c=%0d en=%b required 1 %0d 1 0 0", ok, en, rsp_err, rsp_c, core_en, TO);
    end
    core_mode = 0;
    @(posedge clk); #1;
    rand_ops(1); req1_valid = 1'b1;
    c1 = golden(req1_p, req1_e, req1_m);
    @(negedge clk);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(50, ok, en);
    tests++;
    if (!ok || rsp_err !== 1'b0 || rsp_c !== c1 || rsp_id !== 1'b1) begin
      fails++; $display("FAIL timeout_next: ok=%0d err=%b c=%0d id=%b required 1 0 %0d 1", ok, rsp_err, rsp_c, rsp_id, c1);
    end
    @(negedge clk);
  endtask
`endif

  // Randomised traffic against a transaction-level round-robin model
  task automatic test_random();
    bit           model_idle = 1'b1, release_idle = 1'b0, model_last = 1'b1;
    bit           e0, e1;
    bit           q_id[$];
    logic [W-1:0] q_c[$];
    int           n_jobs = 0;
    localparam int TARGET = 25;
    do_reset();
    for (int cyc = 0; cyc < 3000 && (n_jobs < TARGET || q_c.size() > 0); cyc++) begin
      @(posedge clk); #1;
      if (release_idle) begin model_idle = 1'b1; release_idle = 1'b0; end
      rand_ops(0); rand_ops(1);
      req0_valid = (n_jobs < TARGET) && ($urandom_range(0, 2) != 0);
      req1_valid = (n_jobs < TARGET) && ($urandom_range(0, 2) != 0);
      rsp_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      e0 = model_idle && req0_valid && (!req1_valid || model_last);
      e1 = model_idle && req1_valid && !e0;
      tests++;
      if ({req0_ready, req1_ready} !== {e0, e1} || busy !== !model_idle) begin
        fails++;
        $display("FAIL rand_grant@%0d: rdy=%b%b busy=%b required %b%b %b", cyc, req0_ready, req1_ready,
                 busy, e0, e1, !model_idle);
      end
      if (e0 || e1) begin
        q_id.push_back(e1);
        q_c.push_back(e1 ? golden(req1_p, req1_e, req1_m) : golden(req0_p, req0_e, req0_m));
        model_last = e1; model_idle = 1'b0; n_jobs++;
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (q_c.size() == 0) begin
          fails++; $display("FAIL rand_spurious@%0d: rsp_valid=1 required 0", cyc);
        end else begin
          if (rsp_id !== q_id[0] || rsp_c !== q_c[0] || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL rand_rsp@%0d: id=%b c=%0d err=%b required %b %0d 0", cyc, rsp_id, rsp_c, rsp_err,
                     q_id[0], q_c[0]);
          end
          void'(q_id.pop_front()); void'(q_c.pop_front());
          release_idle = 1'b1;
        end
      end
    end
    tests++;
    if (n_jobs != TARGET || q_c.size() != 0) begin
      fails++; $display("FAIL rand_drain: jobs=%0d pending=%0d required %0d 0", n_jobs, q_c.size(), TARGET);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
`ifdef RSA_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
